// File: rtl/udm_host_pkg.sv
// udm_host_pkg: UDM host protocol constants, FSM state type and frame byte builder.
package udm_host_pkg;

    localparam logic [7:0]  UDM_SYNC         = 8'h55;
    localparam logic [7:0]  UDM_CMD_WR       = 8'h81;
    localparam logic [7:0]  UDM_CMD_RD       = 8'h82;
    localparam int unsigned UDM_WR_FRAME_LEN = 14;
    localparam int unsigned UDM_RD_FRAME_LEN = 10;
    localparam int unsigned UDM_RSP_LEN      = 4;
    localparam logic [31:0] UDM_XFER_LEN     = 32'h0000_0004;
    localparam logic [31:0] UDM_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP
    } udm_state_e;

    // Byte idx of a command frame; multibyte fields are little-endian.
    function automatic logic [7:0] udm_frame_byte(
        input logic [3:0]  idx,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        logic [7:0] b;
        b = '0;
        case (idx)
            4'd0:    b = UDM_SYNC;
            4'd1:    b = we ? UDM_CMD_WR : UDM_CMD_RD;
            4'd2:    b = addr[7:0];
            4'd3:    b = addr[15:8];
            4'd4:    b = addr[23:16];
            4'd5:    b = addr[31:24];
            4'd6:    b = UDM_XFER_LEN[7:0];
            4'd7:    b = UDM_XFER_LEN[15:8];
            4'd8:    b = UDM_XFER_LEN[23:16];
            4'd9:    b = UDM_XFER_LEN[31:24];
            4'd10:   b = wdata[7:0];
            4'd11:   b = wdata[15:8];
            4'd12:   b = wdata[23:16];
            4'd13:   b = wdata[31:24];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udm_uart_phy.sv
// udm_uart_phy: 8N1 byte-level UART transmitter and receiver sharing one BIT_CYC bit timer length.
module udm_uart_phy #(
    parameter int unsigned BIT_CYC = 109
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_start_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_done_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_ferr_o
);

    localparam int unsigned CW = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_CYC = CW'(BIT_CYC / 2 - 1);

    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_end;

    logic [2:0]    rx_sync_q, rx_sync_d;
    logic          rx_busy_q, rx_busy_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_line;

    // A new start may be loaded in the last stop-bit cycle, giving gapless back-to-back bytes.
    always_comb begin
        tx_end     = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_line_d  = tx_shift_q[1];
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
        end
        if (tx_start_i && (!tx_busy_q || tx_end)) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, tx_byte_i, 1'b0};
            tx_line_d  = 1'b0;
        end
    end

    assign rx_line = rx_sync_q[1];

    // rx_sync_q[2] holds the previous synchronised level for falling-edge detection.
    always_comb begin
        rx_sync_d  = {rx_sync_q[1:0], rx_i};
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        if (!rx_busy_q) begin
            if (rx_sync_q[2] && !rx_line) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = HALF_CYC;
                rx_bit_d  = '0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
            rx_cnt_d = BIT_LAST;
            if (rx_bit_q == 4'd0) begin
                if (rx_line) begin
                    rx_busy_d = 1'b0;
                end else begin
                    rx_bit_d = 4'd1;
                end
            end else if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                if (rx_line) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = rx_shift_q;
                end else begin
                    rx_ferr_d = 1'b1;
                end
            end else begin
                rx_shift_d = {rx_line, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_line_q  <= 1'b1;
            rx_sync_q  <= '1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            rx_ferr_q  <= 1'b0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_sync_q  <= rx_sync_d;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign tx_done_o  = tx_end;
    assign tx_o       = tx_line_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_byte_o  = rx_byte_q;
    assign rx_ferr_o  = rx_ferr_q;

endmodule

// File: rtl/udm_host_master.sv
// udm_host_master: UDM host initiator; serialises single-word bus requests into UART command frames.
// Define UDM_HOST_TIMEOUT_EN to bound the read-response wait to RSP_TIMEOUT cycles.
module udm_host_master #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD_RATE   = 921600,
    parameter int unsigned RSP_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        resp_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        tx_o,
    input  logic        rx_i
);

    import udm_host_pkg::*;

    localparam int unsigned BIT_CYC_RAW = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned BIT_CYC     = (BIT_CYC_RAW < 4) ? 4 : BIT_CYC_RAW;
    localparam int unsigned GAP_W       = $clog2(BIT_CYC + 1);
    localparam int unsigned TMO_W       = $clog2(RSP_TIMEOUT + 1);

`ifdef UDM_HOST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    udm_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic          in_flight_q, in_flight_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]    rsp_cnt_q, rsp_cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic          ack_q, ack_d;
    logic          resp_q, resp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_ferr;
    logic [3:0]    last_idx;

    udm_uart_phy #(
        .BIT_CYC(BIT_CYC)
    ) u_phy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tx_start_i (tx_start),
        .tx_byte_i  (tx_byte),
        .tx_done_o  (tx_done),
        .tx_o       (tx_o),
        .rx_i       (rx_i),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte),
        .rx_ferr_o  (rx_ferr)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_idx_d  = byte_idx_q;
        in_flight_d = in_flight_q;
        gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
        rsp_cnt_d   = rsp_cnt_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        ack_d       = 1'b0;
        resp_d      = 1'b0;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        err_d       = err_q | rx_ferr;
        tx_start    = 1'b0;
        last_idx    = we_q ? 4'(UDM_WR_FRAME_LEN - 1) : 4'(UDM_RD_FRAME_LEN - 1);
        tx_byte     = udm_frame_byte(in_flight_q ? byte_idx_q + 4'd1 : 4'd0,
                                     we_q, addr_q, wdata_q);

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d        = we_i;
                    addr_d      = addr_i;
                    wdata_d     = wdata_i;
                    byte_idx_d  = '0;
                    in_flight_d = 1'b0;
                    ack_d       = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                // The first byte waits out the inter-frame guard time left by the previous frame.
                if (!in_flight_q) begin
                    if (gap_q == '0) begin
                        tx_start    = 1'b1;
                        in_flight_d = 1'b1;
                    end
                end else if (tx_done) begin
                    if (byte_idx_q == last_idx) begin
                        in_flight_d = 1'b0;
                        gap_d       = GAP_W'(BIT_CYC);
                        if (we_q) begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            rsp_cnt_d = '0;
                            tmo_d     = '0;
                            state_d   = ST_WAIT_RSP;
                        end
                    end else begin
                        tx_start   = 1'b1;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (rx_valid) begin
                    acc_d     = {rx_byte, acc_q[31:8]};
                    rsp_cnt_d = rsp_cnt_q + 2'd1;
                    tmo_d     = '0;
                    if (rsp_cnt_q == 2'(UDM_RSP_LEN - 1)) begin
                        rdata_d = {rx_byte, acc_q[31:8]};
                        resp_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (TMO_EN) begin
                    if (rx_ferr) begin
                        tmo_d = '0;
                    end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
                        rdata_d = UDM_TIMEOUT_DATA;
                        resp_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_idx_q  <= '0;
            in_flight_q <= 1'b0;
            gap_q       <= '0;
            rsp_cnt_q   <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            ack_q       <= 1'b0;
            resp_q      <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_idx_q  <= byte_idx_d;
            in_flight_q <= in_flight_d;
            gap_q       <= gap_d;
            rsp_cnt_q   <= rsp_cnt_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign ack_o   = ack_q;
    assign resp_o  = resp_q;
    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_udm_host_master.sv
// tb_udm_host_master: randomized self-checking bench with a UART line model on both tx_o and rx_i.
module tb_udm_host_master;

    // Clock scaled down so each frame stays short; 16 MHz / 921600 rounds to 17 cycles per bit.
    localparam int unsigned CLK_HZ = 16000000;
    localparam int unsigned BAUD   = 921600;
    localparam int unsigned B      = 17;

    logic        clk = 1'b0;
    logic        rst, req, we, ack, resp, busy, err, tx, rx;
    logic [31:0] addr, wdata, rdata;

    int unsigned cyc = 0;
    int          passed = 0, total = 0;
    int          ack_cnt = 0, resp_cnt = 0;
    logic [7:0]  txq[$];
    int unsigned txt[$];
    int unsigned first_t, last_t;

    udm_host_master #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .RSP_TIMEOUT(500)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack),
        .resp_o  (resp),
        .rdata_o (rdata),
        .busy_o  (busy),
        .err_o   (err),
        .tx_o    (tx),
        .rx_i    (rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ack === 1'b1) ack_cnt++;
        if (resp === 1'b1) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Line decoder for tx_o: records each byte and the cycle its start bit first appears.
    initial begin : tx_mon
        logic prev;
        logic [7:0] b;
        int unsigned t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                repeat (B / 2) @(negedge clk);
                check("tx_start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = tx;
                end
                repeat (B) @(negedge clk);
                check("tx_stop_bit", {31'd0, tx}, 32'd1);
                txq.push_back(b);
                txt.push_back(t0);
                prev = tx;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic uart_tx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * B) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check(tag, txq.size(), n);
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        req = 1'b1; we = w; addr = a; wdata = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack !== 1'b1 && k < 40 * B);
        req = 1'b0;
        check("req_acked", {31'd0, ack}, 32'd1);
    endtask

    // Reference frame: sync, cmd, addr LE, length 4 LE, data LE for writes; gapless bytes.
    task automatic check_frame(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] e[$];
        int n;
        e = {};
        e.push_back(8'h55);
        e.push_back(w ? 8'h81 : 8'h82);
        for (int i = 0; i < 4; i++) e.push_back(8'((a >> (8 * i)) & 32'hFF));
        e.push_back(8'h04);
        repeat (3) e.push_back(8'h00);
        if (w) for (int i = 0; i < 4; i++) e.push_back(8'((d >> (8 * i)) & 32'hFF));
        n = e.size();
        wait_bytes(n, "frame_len");
        if (txq.size() >= n) begin
            first_t = txt[0];
            last_t  = txt[n - 1];
            for (int i = 0; i < n; i++) begin
                check($sformatf("frame_byte%0d", i), {24'd0, txq[i]}, {24'd0, e[i]});
                if (i > 0) check($sformatf("byte_spacing%0d", i), txt[i] - txt[i - 1], 10 * B);
            end
            repeat (n) begin
                void'(txq.pop_front());
                void'(txt.pop_front());
            end
        end
    endtask

    task automatic wait_resp(input int r0);
        int k;
        k = 0;
        while (resp_cnt == r0 && k < 30 * B) begin
            @(negedge clk);
            k++;
        end
        repeat (3 * B) @(negedge clk);
        check("rd_resp_count", resp_cnt, r0 + 1);
        check("rd_busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d);
        int r0, k;
        r0 = resp_cnt;
        do_req(1'b1, a, d);
        check_frame(1'b1, a, d);
        k = 0;
        while (busy !== 1'b0 && k < 4 * B) begin
            @(negedge clk);
            k++;
        end
        check("wr_busy_drop_cyc", cyc - last_t, 10 * B);
        repeat (2 * B) @(negedge clk);
        check("wr_no_resp", resp_cnt, r0);
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [31:0] d);
        int r0;
        r0 = resp_cnt;
        do_req(1'b0, a, 32'd0);
        check_frame(1'b0, a, 32'd0);
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) uart_tx(8'((d >> (8 * i)) & 32'hFF), 1'b1);
        wait_resp(r0);
        check("rd_data", rdata, d);
    endtask

    initial begin : main
        logic [31:0] a, d;
        logic [7:0]  by[4];
        int a0, r0, k;
        int unsigned t1;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_resp", {31'd0, resp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        write_txn(32'h8000_0000, 32'h1234_5678);
        read_txn(32'h0000_0010, 32'hDEAD_BEEF);

        for (int it = 0; it < 4; it++) begin
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) write_txn(a, d);
            else read_txn(a, d);
        end

        // Requester holds req_i across a whole write: exactly two frames, with an idle guard between.
        a0 = ack_cnt;
        a = $urandom; d = $urandom;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        k = 0;
        while (ack_cnt < a0 + 2 && k < 400 * B) begin
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        check_frame(1'b1, a, d);
        t1 = last_t;
        check_frame(1'b1, a, d);
        check("b2b_gap_ge_bit", {31'd0, (first_t - t1) >= 11 * B}, 32'd1);
        repeat (4 * B) @(negedge clk);
        check("b2b_ack_count", ack_cnt, a0 + 2);

        // Framing error on the second reply byte: err_o sets, that byte is skipped.
        check("err_before_ferr", {31'd0, err}, 32'd0);
        r0 = resp_cnt;
        a = $urandom;
        for (int i = 0; i < 4; i++) by[i] = 8'($urandom);
        do_req(1'b0, a, 32'd0);
        check_frame(1'b0, a, 32'd0);
        repeat (B) @(negedge clk);
        uart_tx(by[0], 1'b1);
        uart_tx(8'($urandom), 1'b0);
        check("ferr_err_set", {31'd0, err}, 32'd1);
        for (int i = 1; i < 4; i++) uart_tx(by[i], 1'b1);
        wait_resp(r0);
        check("ferr_rdata", rdata, {by[3], by[2], by[1], by[0]});
        read_txn($urandom, $urandom);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset during byte 5 of a write, then a normal read.
        do_req(1'b1, $urandom, $urandom);
        wait_bytes(5, "rst_pre_bytes");
        repeat (B) @(negedge clk);
        check("rst_mid_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (12 * B) @(negedge clk);
        txq.delete();
        txt.delete();
        read_txn($urandom, $urandom);

`ifdef UDM_HOST_TIMEOUT_EN
        a = $urandom;
        do_req(1'b0, a, 32'd0);
        check_frame(1'b0, a, 32'd0);
        k = 0;
        while (resp !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tmo_latency", cyc - (last_t + 10 * B), 500);
        check("tmo_rdata", rdata, 32'hDEAD_BEEF);
        check("tmo_err", {31'd0, err}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
